// File: rtl/decode_stage_if.sv
// Fetch/decode/write-back signal bundle for the MIPS decode stage.
// The slave modport is the decode stage; the master is whoever drives it (Fetch, WB, bench).
interface decode_stage_if #(
    parameter int unsigned DATA_W = 32
);
    logic [31:0]       Instr;
    logic [DATA_W-1:0] PC_add4;
    logic              Stall;
    logic              Flush;
    logic              RegWrite_WB;
    logic [4:0]        WriteReg_WB;
    logic [DATA_W-1:0] WriteData_WB;

    logic [31:0]       Instr_ID;
    logic [DATA_W-1:0] PC_add4_ID;
    logic              Valid_ID;
    logic [5:0]        Opcode;
    logic [4:0]        Rs;
    logic [4:0]        Rt;
    logic [4:0]        Rd;
    logic [4:0]        Shamt;
    logic [5:0]        Funct;
    logic [DATA_W-1:0] SignImm;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [DATA_W-1:0] BranchAddr;
    logic              PCSrc;

    modport master (
        output Instr, PC_add4, Stall, Flush, RegWrite_WB, WriteReg_WB, WriteData_WB,
        input  Instr_ID, PC_add4_ID, Valid_ID, Opcode, Rs, Rt, Rd, Shamt, Funct,
               SignImm, ReadData1, ReadData2, BranchAddr, PCSrc
    );

    modport slave (
        input  Instr, PC_add4, Stall, Flush, RegWrite_WB, WriteReg_WB, WriteData_WB,
        output Instr_ID, PC_add4_ID, Valid_ID, Opcode, Rs, Rt, Rd, Shamt, Funct,
               SignImm, ReadData1, ReadData2, BranchAddr, PCSrc
    );
endinterface

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: IF/ID register, 32x32 register file, early beq/bne resolution.
// Optional macro DECODE_BYPASS_EN enables same-cycle write-through from the write-back port.
module decode_stage #(
    parameter int unsigned DATA_W    = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input logic           clk,
    input logic           reset,
    decode_stage_if.slave bus
);
    logic [31:0]       instr_q;
    logic [DATA_W-1:0] pc_add4_q;
    logic              valid_q;
    logic [DATA_W-1:0] regs_q [32];

    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [5:0]        opcode;
    logic [DATA_W-1:0] sign_imm;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              wb_en;
    logic              pcsrc;
    logic              squash;

    assign opcode   = instr_q[31:26];
    assign rs       = instr_q[25:21];
    assign rt       = instr_q[20:16];
    assign sign_imm = {{(DATA_W - 16){instr_q[15]}}, instr_q[15:0]};
    assign wb_en    = bus.RegWrite_WB && (bus.WriteReg_WB != 5'd0);

    // A taken branch kills the wrong-path instruction arriving on the same edge.
    assign squash = bus.Flush | pcsrc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q   <= NOP_INSTR;
            pc_add4_q <= '0;
            valid_q   <= 1'b0;
        end else if (squash) begin
            instr_q   <= NOP_INSTR;
            pc_add4_q <= '0;
            valid_q   <= 1'b0;
        end else if (!bus.Stall) begin
            instr_q   <= bus.Instr;
            pc_add4_q <= bus.PC_add4;
            valid_q   <= 1'b1;
        end
    end

    // Writes proceed regardless of Stall so a stalled consumer sees the producer's result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[bus.WriteReg_WB] <= bus.WriteData_WB;
        end
    end

    always_comb begin
        rd1 = (rs == 5'd0) ? '0 : regs_q[rs];
        rd2 = (rt == 5'd0) ? '0 : regs_q[rt];
`ifdef DECODE_BYPASS_EN
        if (wb_en && (bus.WriteReg_WB == rs)) begin
            rd1 = bus.WriteData_WB;
        end
        if (wb_en && (bus.WriteReg_WB == rt)) begin
            rd2 = bus.WriteData_WB;
        end
`endif
    end

    // Stall gating keeps operands still waiting on a load from steering Fetch.
    always_comb begin
        pcsrc = 1'b0;
        if (valid_q && !bus.Stall) begin
            if (opcode == 6'b000100) begin
                pcsrc = (rd1 == rd2);
            end else if (opcode == 6'b000101) begin
                pcsrc = (rd1 != rd2);
            end
        end
    end

    assign bus.Instr_ID   = instr_q;
    assign bus.PC_add4_ID = pc_add4_q;
    assign bus.Valid_ID   = valid_q;
    assign bus.Opcode     = opcode;
    assign bus.Rs         = rs;
    assign bus.Rt         = rt;
    assign bus.Rd         = instr_q[15:11];
    assign bus.Shamt      = instr_q[10:6];
    assign bus.Funct      = instr_q[5:0];
    assign bus.SignImm    = sign_imm;
    assign bus.ReadData1  = rd1;
    assign bus.ReadData2  = rd2;
    assign bus.BranchAddr = pc_add4_q + {sign_imm[DATA_W-3:0], 2'b00};
    assign bus.PCSrc      = pcsrc;
endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; expected values are hand-computed.
// Inputs change and outputs are sampled 1ns after rising edges, well away from the next edge.
module tb_decode_stage;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    decode_stage_if #(.DATA_W(32)) bus ();

    decode_stage #(
        .DATA_W   (32),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_instr"}, bus.Instr_ID, 32'h0);
        chk({tag, "_pc"}, bus.PC_add4_ID, 32'h0);
        chk({tag, "_valid"}, {31'd0, bus.Valid_ID}, 32'd0);
        chk({tag, "_rd1"}, bus.ReadData1, 32'h0);
        chk({tag, "_rd2"}, bus.ReadData2, 32'h0);
        chk({tag, "_pcsrc"}, {31'd0, bus.PCSrc}, 32'd0);
        chk({tag, "_baddr"}, bus.BranchAddr, 32'h0);
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        reset            = 1'b0;
        bus.Instr        = 32'h0;
        bus.PC_add4      = 32'h0;
        bus.Stall        = 1'b0;
        bus.Flush        = 1'b0;
        bus.RegWrite_WB  = 1'b0;
        bus.WriteReg_WB  = 5'd0;
        bus.WriteData_WB = 32'h0;
        #2;
        chk_reset_state("rst");

        // Release reset between edges; present addi $8,$0,5.
        #10;
        reset       = 1'b1;
        bus.Instr   = 32'h2008_0005;
        bus.PC_add4 = 32'd4;
        #1;
        chk("pre_edge_instr", bus.Instr_ID, 32'h0);
        chk("pre_edge_valid", {31'd0, bus.Valid_ID}, 32'd0);
        tick();
        chk("addi_instr", bus.Instr_ID, 32'h2008_0005);
        chk("addi_pc", bus.PC_add4_ID, 32'd4);
        chk("addi_rt", {27'd0, bus.Rt}, 32'd8);
        chk("addi_opcode", {26'd0, bus.Opcode}, 32'd8);
        chk("addi_simm", bus.SignImm, 32'd5);
        chk("addi_valid", {31'd0, bus.Valid_ID}, 32'd1);

        // $8 <= DEADBEEF while add $9,$8,$8 enters IF/ID.
        bus.RegWrite_WB  = 1'b1;
        bus.WriteReg_WB  = 5'd8;
        bus.WriteData_WB = 32'hDEAD_BEEF;
        bus.Instr        = 32'h0108_4820;
        bus.PC_add4      = 32'd8;
        tick();
        bus.RegWrite_WB = 1'b0;
        #1;
        chk("add_rs", {27'd0, bus.Rs}, 32'd8);
        chk("add_rd", {27'd0, bus.Rd}, 32'd9);
        chk("add_funct", {26'd0, bus.Funct}, 32'h20);
        chk("add_rd1", bus.ReadData1, 32'hDEAD_BEEF);
        chk("add_rd2", bus.ReadData2, 32'hDEAD_BEEF);

        // Write to $0 is discarded.
        bus.RegWrite_WB  = 1'b1;
        bus.WriteReg_WB  = 5'd0;
        bus.WriteData_WB = 32'h1234;
        bus.Instr        = 32'h0000_0000;
        tick();
        chk("r0_bypass_rd1", bus.ReadData1, 32'h0);
        tick();
        bus.RegWrite_WB = 1'b0;
        #1;
        chk("r0_rd1", bus.ReadData1, 32'h0);

        // $1 = $2 = 7, then beq $1,$2,-2 at PC+4 = 16.
        bus.RegWrite_WB  = 1'b1;
        bus.WriteReg_WB  = 5'd1;
        bus.WriteData_WB = 32'd7;
        tick();
        bus.WriteReg_WB = 5'd2;
        tick();
        bus.RegWrite_WB = 1'b0;
        bus.Instr       = 32'h1022_FFFE;
        bus.PC_add4     = 32'd16;
        tick();
        bus.Instr   = 32'h2009_0001;
        bus.PC_add4 = 32'd20;
        #1;
        chk("beq_rd1", bus.ReadData1, 32'd7);
        chk("beq_rd2", bus.ReadData2, 32'd7);
        chk("beq_pcsrc", {31'd0, bus.PCSrc}, 32'd1);
        chk("beq_baddr", bus.BranchAddr, 32'd8);
        tick();
        chk("beq_squash_valid", {31'd0, bus.Valid_ID}, 32'd0);
        chk("beq_squash_instr", bus.Instr_ID, 32'h0);
        chk("beq_squash_pc", bus.PC_add4_ID, 32'h0);
        chk("beq_squash_pcsrc", {31'd0, bus.PCSrc}, 32'd0);

        // bne with equal operands: not taken, wrong-path instruction loads normally.
        bus.Instr   = 32'h1422_FFFE;
        bus.PC_add4 = 32'd16;
        tick();
        bus.Instr   = 32'h2009_0001;
        bus.PC_add4 = 32'd20;
        #1;
        chk("bne_pcsrc", {31'd0, bus.PCSrc}, 32'd0);
        chk("bne_baddr", bus.BranchAddr, 32'd8);
        tick();
        chk("bne_next_instr", bus.Instr_ID, 32'h2009_0001);
        chk("bne_next_valid", {31'd0, bus.Valid_ID}, 32'd1);

        // Taken beq held by Stall for 3 cycles; $3 <= 0x11 during the stall.
        bus.Instr   = 32'h1022_FFFE;
        bus.PC_add4 = 32'd16;
        tick();
        chk("stall_pre_pcsrc", {31'd0, bus.PCSrc}, 32'd1);
        bus.Stall = 1'b1;
        #1;
        chk("stall_pcsrc0", {31'd0, bus.PCSrc}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.Instr        = 32'hAC00_0000 + i;
            bus.PC_add4      = 32'd100 + 4 * i;
            bus.RegWrite_WB  = (i == 0);
            bus.WriteReg_WB  = 5'd3;
            bus.WriteData_WB = 32'h11;
            tick();
            chk("stall_instr", bus.Instr_ID, 32'h1022_FFFE);
            chk("stall_pc", bus.PC_add4_ID, 32'd16);
            chk("stall_valid", {31'd0, bus.Valid_ID}, 32'd1);
            chk("stall_pcsrc", {31'd0, bus.PCSrc}, 32'd0);
        end
        bus.RegWrite_WB = 1'b0;
        bus.Flush       = 1'b1;
        tick();
        chk("flush_stall_instr", bus.Instr_ID, 32'h0);
        chk("flush_stall_valid", {31'd0, bus.Valid_ID}, 32'd0);

        // Same-cycle write of $3 = 0x55 while decoding Rs = 3.
        bus.Flush   = 1'b0;
        bus.Stall   = 1'b0;
        bus.Instr   = 32'h0060_0000;
        bus.PC_add4 = 32'd40;
        tick();
        chk("rs3_old", bus.ReadData1, 32'h11);
        bus.RegWrite_WB  = 1'b1;
        bus.WriteReg_WB  = 5'd3;
        bus.WriteData_WB = 32'h55;
        #1;
`ifdef DECODE_BYPASS_EN
        chk("rs3_same_cycle", bus.ReadData1, 32'h55);
`else
        chk("rs3_same_cycle", bus.ReadData1, 32'h11);
`endif
        tick();
        bus.RegWrite_WB = 1'b0;
        #1;
        chk("rs3_after_edge", bus.ReadData1, 32'h55);
        chk("rs3_valid", {31'd0, bus.Valid_ID}, 32'd1);

        // Asynchronous reset mid-cycle, then first edge after release loads normally.
        #2;
        reset = 1'b0;
        #1;
        chk_reset_state("async_rst");
        #1;
        reset       = 1'b1;
        bus.Instr   = 32'h2008_0005;
        bus.PC_add4 = 32'd4;
        tick();
        chk("post_rst_instr", bus.Instr_ID, 32'h2008_0005);
        chk("post_rst_valid", {31'd0, bus.Valid_ID}, 32'd1);
        chk("post_rst_r8", bus.ReadData2, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the MIPS datapath, directly downstream of the Fetch stage. Latches `Instr`/`PC_add4` into an IF/ID pipeline register with stall and flush control. Hosts the 32×32 register file with a write-back port and extracts the instruction fields. Resolves `beq`/`bne` early and returns `PCSrc`/`BranchAddr` to Fetch.

## Interface
- `DATA_W`, 32: datapath width.
- `NOP_INSTR`, 32'h0000_0000: instruction value loaded on reset or flush (`sll $0,$0,0`).

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `Instr` in 32: fetched instruction from Fetch.
- `PC_add4` in 32: PC+4 of the fetched instruction.
- `Stall` in 1: hold IF/ID contents (load-use hazard).
- `Flush` in 1: external bubble request.
- `RegWrite_WB` in 1: write-back enable.
- `WriteReg_WB` in 5: write-back destination.
- `WriteData_WB` in 32: write-back data.
- `Instr_ID` out 32: registered instruction.
- `PC_add4_ID` out 32: registered PC+4.
- `Valid_ID` out 1: IF/ID holds a real instruction.
- `Opcode` out 6: instruction field [31:26].
- `Rs` out 5: instruction field [25:21].
- `Rt` out 5: instruction field [20:16].
- `Rd` out 5: instruction field [15:11].
- `Shamt` out 5: instruction field [10:6].
- `Funct` out 6: instruction field [5:0].
- `SignImm` out 32: `{{16{Instr_ID[15]}}, Instr_ID[15:0]}`.
- `ReadData1` out 32: register file read of `Rs`.
- `ReadData2` out 32: register file read of `Rt`.
- `BranchAddr` out 32: branch target to Fetch.
- `PCSrc` out 1: branch taken, to Fetch.

## Operation
- IF/ID register update on each `clk` rising edge, highest priority first:
  - `Squash` (`Flush` | `PCSrc`): `Instr_ID`←`NOP_INSTR`, `PC_add4_ID`←0, `Valid_ID`←0.
  - `Stall`: all IF/ID contents hold.
  - Otherwise: `Instr_ID`←`Instr`, `PC_add4_ID`←`PC_add4`, `Valid_ID`←1.
- Flush overrides Stall when both are asserted in the same cycle.
- Field outputs and `SignImm` are combinational from `Instr_ID`.
- Register file:
  - 32 entries; written on the rising edge when `RegWrite_WB` is 1 and `WriteReg_WB` is not 0.
  - Register 0 always reads 0, and writes to it are discarded.
  - Reads are combinational.
- Branch target: `BranchAddr` = `PC_add4_ID` + (`SignImm` << 2), computed modulo 2^32 (wrap ignored).
- Branch decision: `PCSrc` = `Valid_ID` & ~`Stall` & ((`Opcode`==6'b000100 & `ReadData1`==`ReadData2`) | (`Opcode`==6'b000101 & `ReadData1`!=`ReadData2`)).
- All other opcodes give `PCSrc`=0. Stall gates `PCSrc` so that branch operands still awaiting a load are never used.
- A taken branch squashes the wrong-path instruction entering IF/ID on the same edge (one delay-slot bubble).

## Timing
- Reset (asynchronous, `reset`=0) drives:
  - `Instr_ID`=`NOP_INSTR`, `PC_add4_ID`=0, `Valid_ID`=0.
  - All registers = 0, so `ReadData1`=`ReadData2`=0.
  - `PCSrc`=0, `BranchAddr`=0.
- Reset deasserted mid-operation: the first edge after release loads Fetch outputs normally.
- Latency: `Instr` to `Instr_ID` is 1 cycle. `PCSrc`/`BranchAddr` are valid combinationally in the same cycle the branch sits in IF/ID, and Fetch samples them on the next edge.
- Write-back and read in the same cycle:
  - Without bypass, the read returns the old value; the new value is visible after the edge.
- Sustained `Stall`: outputs are stable for every stalled cycle, and the register file still accepts writes.

## Configuration
- `DECODE_BYPASS_EN` defined: write-through bypass. When `RegWrite_WB` is 1, `WriteReg_WB`!=0 and `WriteReg_WB` equals `Rs` (or `Rt`), `ReadData1` (or `ReadData2`) returns `WriteData_WB` in the same cycle. `PCSrc` uses the bypassed values.
- `DECODE_BYPASS_EN` undefined: no bypass; reads reflect register contents only. The hazard unit must stall one extra cycle.

## Test plan
- Reset then release; `Instr`=32'h2008_0005 with `PC_add4`=4 -> after one edge `Instr_ID`=32'h2008_0005, `Rt`=8, `SignImm`=5, `Valid_ID`=1; before the edge all outputs are at reset values.
- Write back $8=32'hDEAD_BEEF, then decode 32'h0108_4820 (`add $9,$8,$8`) -> `ReadData1`=`ReadData2`=32'hDEAD_BEEF. Write back to $0 with 32'h1234 -> reading $0 returns 0.
- $1=$2=7 and `beq $1,$2,-2` (32'h1022_FFFE) with `PC_add4_ID`=16 -> `PCSrc`=1, `BranchAddr`=8; next edge `Valid_ID`=0, `Instr_ID`=NOP. Same test with `bne` -> `PCSrc`=0.
- Hold `Stall`=1 for 3 cycles while `Instr` changes -> `Instr_ID` unchanged and `PCSrc`=0 even for a taken beq. Assert `Flush` together with `Stall` -> bubble loaded.
- Same-cycle write of $3=32'h55 while decoding `Rs`=3 -> 32'h55 with `DECODE_BYPASS_EN` defined, the old value without it.
- Assert `reset` low mid-stream with `Valid_ID`=1 -> outputs return to reset values immediately, asynchronously, without waiting for `clk`.
